// File: rtl/traffic_light_controller_param.sv
// Parametrised four-approach traffic light controller with demand-driven side phase,
// latched pedestrian all-red walk phase and optional night flash (macro NIGHT_FLASH_EN).
module traffic_light_controller_param #(
    parameter int unsigned T_MAIN  = 7,
    parameter int unsigned T_MT    = 5,
    parameter int unsigned T_SIDE  = 3,
    parameter int unsigned T_Y     = 2,
    parameter int unsigned T_PED   = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned FLASH_P = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_req,
    input  logic       night,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_M12 = 3'd0,
        S_M2Y = 3'd1,
        S_MT  = 3'd2,
        S_MY  = 3'd3,
        S_SG  = 3'd4,
        S_SY  = 3'd5,
        S_PED = 3'd6
`ifdef NIGHT_FLASH_EN
        , S_NIGHT = 3'd7
`endif
    } state_t;

    localparam logic [2:0] L_R   = 3'b100;
    localparam logic [2:0] L_Y   = 3'b010;
    localparam logic [2:0] L_G   = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    state_t           r_state, w_next, w_norm;
    logic [CNT_W-1:0] r_cnt, w_cnt_next, w_dur;
    logic             w_done;
    logic             r_side_pend, r_ped_pend;
    logic [2:0]       r_M1, r_M2, r_MT, r_S;
    logic             r_walk;
    logic [2:0]       w_M1, w_M2, w_MT, w_S;
    logic             w_walk;

`ifdef NIGHT_FLASH_EN
    logic [CNT_W-1:0] r_fcnt, w_fcnt_next;
    logic             r_lit, w_lit_next;
`else
    logic             w_unused;
    assign w_unused = night ^ (FLASH_P == 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_M12;
            r_cnt       <= '0;
            r_side_pend <= 1'b0;
            r_ped_pend  <= 1'b0;
            r_M1        <= L_G;
            r_M2        <= L_G;
            r_MT        <= L_R;
            r_S         <= L_R;
            r_walk      <= 1'b0;
`ifdef NIGHT_FLASH_EN
            r_fcnt      <= '0;
            r_lit       <= 1'b1;
`endif
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            // Entering the serving phase clears the flag even if a request arrives on that edge
            r_side_pend <= (w_done && w_next == S_SG)  ? 1'b0 : (r_side_pend | side_req);
            r_ped_pend  <= (w_done && w_next == S_PED) ? 1'b0 : (r_ped_pend | ped_req);
            r_M1        <= w_M1;
            r_M2        <= w_M2;
            r_MT        <= w_MT;
            r_S         <= w_S;
            r_walk      <= w_walk;
`ifdef NIGHT_FLASH_EN
            r_fcnt      <= w_fcnt_next;
            r_lit       <= w_lit_next;
`endif
        end
    end

    always_comb begin
        w_dur  = '0;
        w_norm = S_M12;
        w_done = 1'b1;
        case (r_state)
            S_M12: begin w_dur = CNT_W'(T_MAIN - 1); w_norm = S_M2Y; end
            S_M2Y: begin w_dur = CNT_W'(T_Y - 1);    w_norm = S_MT;  end
            S_MT:  begin w_dur = CNT_W'(T_MT - 1);   w_norm = S_MY;  end
            S_MY:  begin
                w_dur  = CNT_W'(T_Y - 1);
                w_norm = r_side_pend ? S_SG : (r_ped_pend ? S_PED : S_M12);
            end
            S_SG:  begin w_dur = CNT_W'(T_SIDE - 1); w_norm = S_SY;  end
            S_SY:  begin
                w_dur  = CNT_W'(T_Y - 1);
                w_norm = r_ped_pend ? S_PED : S_M12;
            end
            S_PED: begin w_dur = CNT_W'(T_PED - 1);  w_norm = S_M12; end
`ifdef NIGHT_FLASH_EN
            S_NIGHT: w_norm = S_MY;
`endif
            default: w_norm = S_M12;
        endcase
        if (r_state inside {S_M12, S_M2Y, S_MT, S_MY, S_SG, S_SY, S_PED})
            w_done = (r_cnt == w_dur);
        w_cnt_next = w_done ? '0 : r_cnt + CNT_W'(1);
`ifdef NIGHT_FLASH_EN
        // Night overrides the next state only at a phase boundary; S_NIGHT re-evaluates every cycle
        w_next = w_done ? (night ? S_NIGHT : w_norm) : r_state;
        w_fcnt_next = '0;
        w_lit_next  = 1'b1;
        if (r_state == S_NIGHT && w_next == S_NIGHT) begin
            if (r_fcnt == CNT_W'(FLASH_P - 1)) begin
                w_lit_next = ~r_lit;
            end else begin
                w_fcnt_next = r_fcnt + CNT_W'(1);
                w_lit_next  = r_lit;
            end
        end
`else
        w_next = w_done ? w_norm : r_state;
`endif
    end

    always_comb begin
        w_walk = 1'b0;
        {w_M1, w_M2, w_MT, w_S} = {L_G, L_G, L_R, L_R};
        case (w_next)
            S_M12: {w_M1, w_M2, w_MT, w_S} = {L_G, L_G, L_R, L_R};
            S_M2Y: {w_M1, w_M2, w_MT, w_S} = {L_G, L_Y, L_R, L_R};
            S_MT:  {w_M1, w_M2, w_MT, w_S} = {L_G, L_R, L_G, L_R};
            S_MY:  {w_M1, w_M2, w_MT, w_S} = {L_Y, L_R, L_Y, L_R};
            S_SG:  {w_M1, w_M2, w_MT, w_S} = {L_R, L_R, L_R, L_G};
            S_SY:  {w_M1, w_M2, w_MT, w_S} = {L_R, L_R, L_R, L_Y};
            S_PED: begin
                {w_M1, w_M2, w_MT, w_S} = {L_R, L_R, L_R, L_R};
                w_walk = 1'b1;
            end
`ifdef NIGHT_FLASH_EN
            S_NIGHT: {w_M1, w_M2, w_MT, w_S} = w_lit_next ? {L_Y, L_Y, L_Y, L_R}
                                                          : {L_OFF, L_OFF, L_OFF, L_OFF};
`endif
            default: {w_M1, w_M2, w_MT, w_S} = {L_G, L_G, L_R, L_R};
        endcase
    end

    assign light_M1 = r_M1;
    assign light_M2 = r_M2;
    assign light_MT = r_MT;
    assign light_S  = r_S;
    assign walk     = r_walk;
    assign phase    = r_state;

endmodule

// File: tb/tb_traffic_light_controller_param.sv
// Directed self-checking bench for traffic_light_controller_param: per-cycle phase/lamp/walk
// checks against hand-written phase schedules; the night test runs only with NIGHT_FLASH_EN.
module tb_traffic_light_controller_param;

    logic       clk = 1'b0;
    logic       rst, side_req, ped_req, night;
    logic [2:0] light_M1, light_M2, light_MT, light_S, phase;
    logic       walk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    traffic_light_controller_param #(
        .T_MAIN(7), .T_MT(5), .T_SIDE(3), .T_Y(2), .T_PED(4), .CNT_W(8), .FLASH_P(4)
    ) dut (
        .clk(clk), .rst(rst), .side_req(side_req), .ped_req(ped_req), .night(night),
        .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT), .light_S(light_S),
        .walk(walk), .phase(phase)
    );

    // {M1,M2,MT,S,walk}; 7 = night lit, 8 = night dark
    function automatic logic [12:0] exp_lamps(input int ph);
        case (ph)
            0: return {3'b001, 3'b001, 3'b100, 3'b100, 1'b0};
            1: return {3'b001, 3'b010, 3'b100, 3'b100, 1'b0};
            2: return {3'b001, 3'b100, 3'b001, 3'b100, 1'b0};
            3: return {3'b010, 3'b100, 3'b010, 3'b100, 1'b0};
            4: return {3'b100, 3'b100, 3'b100, 3'b001, 1'b0};
            5: return {3'b100, 3'b100, 3'b100, 3'b010, 1'b0};
            6: return {3'b100, 3'b100, 3'b100, 3'b100, 1'b1};
            7: return {3'b010, 3'b010, 3'b010, 3'b100, 1'b0};
            default: return 13'b0;
        endcase
    endfunction

    function automatic logic [2:0] exp_phase(input int ph);
        return (ph == 8) ? 3'd7 : 3'(ph);
    endfunction

    task automatic add_seg(input int ph, input int n);
        repeat (n) exp_q.push_back(ph);
    endtask

    task automatic add_loop(input bit side, input bit ped);
        add_seg(0, 7); add_seg(1, 2); add_seg(2, 5); add_seg(3, 2);
        if (side) begin add_seg(4, 3); add_seg(5, 2); end
        if (ped) add_seg(6, 4);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; side_req = 1'b0; ped_req = 1'b0; night = 1'b0;
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; side_req = 1'b0; ped_req = 1'b0; night = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (phase !== 3'd0) $display("FAIL reset_phase got %b exp %b", phase, 3'd0); else n_pass++;
        n_checks++; if (light_M1 !== 3'b001) $display("FAIL reset_M1 got %b exp 001", light_M1); else n_pass++;
        n_checks++; if (light_M2 !== 3'b001) $display("FAIL reset_M2 got %b exp 001", light_M2); else n_pass++;
        n_checks++; if (light_MT !== 3'b100) $display("FAIL reset_MT got %b exp 100", light_MT); else n_pass++;
        n_checks++; if (light_S !== 3'b100) $display("FAIL reset_S got %b exp 100", light_S); else n_pass++;
        n_checks++; if (walk !== 1'b0) $display("FAIL reset_walk got %b exp 0", walk); else n_pass++;
        step();
        n_checks++; if (phase !== 3'd0) $display("FAIL reset_hold got %b exp %b", phase, 3'd0); else n_pass++;
    endtask

    task automatic test_idle();
        do_reset();
        repeat (4) add_loop(0, 0);
        add_seg(0, 1);
        for (int c = 0; c < exp_q.size(); c++) begin
            if (c > 0) step();
            n_checks++;
            if ({phase, light_M1, light_M2, light_MT, light_S, walk} !== {exp_phase(exp_q[c]), exp_lamps(exp_q[c])})
                $display("FAIL idle c=%0d got %h exp %h", c,
                         {phase, light_M1, light_M2, light_MT, light_S, walk}, {exp_phase(exp_q[c]), exp_lamps(exp_q[c])});
            else n_pass++;
`ifndef NIGHT_FLASH_EN
            night = 1'b1;
`endif
        end
        night = 1'b0;
    endtask

    task automatic test_side();
        do_reset();
        add_loop(1, 0); add_loop(0, 0); add_seg(0, 1);
        for (int c = 0; c < exp_q.size(); c++) begin
            if (c > 0) step();
            n_checks++;
            if ({phase, light_M1, light_M2, light_MT, light_S, walk} !== {exp_phase(exp_q[c]), exp_lamps(exp_q[c])})
                $display("FAIL side c=%0d got %h exp %h", c,
                         {phase, light_M1, light_M2, light_MT, light_S, walk}, {exp_phase(exp_q[c]), exp_lamps(exp_q[c])});
            else n_pass++;
            side_req = (c == 3);
        end
        side_req = 1'b0;
    endtask

    task automatic test_side_late();
        do_reset();
        add_loop(0, 0); add_loop(1, 0); add_seg(0, 1);
        for (int c = 0; c < exp_q.size(); c++) begin
            if (c > 0) step();
            n_checks++;
            if ({phase, light_M1, light_M2, light_MT, light_S, walk} !== {exp_phase(exp_q[c]), exp_lamps(exp_q[c])})
                $display("FAIL side_late c=%0d got %h exp %h", c,
                         {phase, light_M1, light_M2, light_MT, light_S, walk}, {exp_phase(exp_q[c]), exp_lamps(exp_q[c])});
            else n_pass++;
            side_req = (c == 15);
        end
        side_req = 1'b0;
    endtask

    task automatic test_ped();
        do_reset();
        add_loop(0, 1); add_loop(0, 0); add_seg(0, 1);
        for (int c = 0; c < exp_q.size(); c++) begin
            if (c > 0) step();
            n_checks++;
            if ({phase, light_M1, light_M2, light_MT, light_S, walk} !== {exp_phase(exp_q[c]), exp_lamps(exp_q[c])})
                $display("FAIL ped c=%0d got %h exp %h", c,
                         {phase, light_M1, light_M2, light_MT, light_S, walk}, {exp_phase(exp_q[c]), exp_lamps(exp_q[c])});
            else n_pass++;
            ped_req = (c == 10);
        end
        ped_req = 1'b0;
    endtask

    task automatic test_both();
        do_reset();
        add_loop(1, 1); add_seg(0, 1);
        for (int c = 0; c < exp_q.size(); c++) begin
            if (c > 0) step();
            n_checks++;
            if ({phase, light_M1, light_M2, light_MT, light_S, walk} !== {exp_phase(exp_q[c]), exp_lamps(exp_q[c])})
                $display("FAIL both c=%0d got %h exp %h", c,
                         {phase, light_M1, light_M2, light_MT, light_S, walk}, {exp_phase(exp_q[c]), exp_lamps(exp_q[c])});
            else n_pass++;
            side_req = (c == 2);
            ped_req  = (c == 2);
        end
        side_req = 1'b0; ped_req = 1'b0;
    endtask

    // side_req again on the edge entering S_SG: the clear wins, next loop has no side phase
    task automatic test_clear_wins();
        do_reset();
        add_loop(1, 0); add_loop(0, 0); add_seg(0, 1);
        for (int c = 0; c < exp_q.size(); c++) begin
            if (c > 0) step();
            n_checks++;
            if ({phase, light_M1, light_M2, light_MT, light_S, walk} !== {exp_phase(exp_q[c]), exp_lamps(exp_q[c])})
                $display("FAIL clear_wins c=%0d got %h exp %h", c,
                         {phase, light_M1, light_M2, light_MT, light_S, walk}, {exp_phase(exp_q[c]), exp_lamps(exp_q[c])});
            else n_pass++;
            side_req = (c == 3) || (c == 15);
        end
        side_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        add_loop(0, 1); add_loop(0, 1); add_seg(0, 1);
        for (int c = 0; c < exp_q.size(); c++) begin
            if (c > 0) step();
            n_checks++;
            if ({phase, light_M1, light_M2, light_MT, light_S, walk} !== {exp_phase(exp_q[c]), exp_lamps(exp_q[c])})
                $display("FAIL back_to_back c=%0d got %h exp %h", c,
                         {phase, light_M1, light_M2, light_MT, light_S, walk}, {exp_phase(exp_q[c]), exp_lamps(exp_q[c])});
            else n_pass++;
            ped_req = (c == 10) || (c == 17);
        end
        ped_req = 1'b0;
    endtask

    task automatic test_rst_mid();
        do_reset();
        repeat (11) step();
        n_checks++;
        if (phase !== 3'd2) $display("FAIL rst_mid_pre got %b exp %b", phase, 3'd2); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({phase, light_M1, light_M2, light_MT, light_S, walk} !== {3'd0, exp_lamps(0)})
            $display("FAIL rst_mid_async got %h exp %h", {phase, light_M1, light_M2, light_MT, light_S, walk}, {3'd0, exp_lamps(0)});
        else n_pass++;
        #1 rst = 1'b0;
        exp_q.delete();
        add_seg(0, 7); add_seg(1, 1);
        for (int c = 0; c < exp_q.size(); c++) begin
            if (c > 0) step();
            n_checks++;
            if ({phase, light_M1, light_M2, light_MT, light_S, walk} !== {exp_phase(exp_q[c]), exp_lamps(exp_q[c])})
                $display("FAIL rst_mid c=%0d got %h exp %h", c,
                         {phase, light_M1, light_M2, light_MT, light_S, walk}, {exp_phase(exp_q[c]), exp_lamps(exp_q[c])});
            else n_pass++;
        end
    endtask

`ifdef NIGHT_FLASH_EN
    task automatic test_night();
        do_reset();
        add_seg(0, 7); add_seg(1, 2); add_seg(2, 5);
        add_seg(7, 4); add_seg(8, 4); add_seg(7, 4);
        add_seg(3, 2); add_seg(0, 1);
        for (int c = 0; c < exp_q.size(); c++) begin
            if (c > 0) step();
            n_checks++;
            if ({phase, light_M1, light_M2, light_MT, light_S, walk} !== {exp_phase(exp_q[c]), exp_lamps(exp_q[c])})
                $display("FAIL night c=%0d got %h exp %h", c,
                         {phase, light_M1, light_M2, light_MT, light_S, walk}, {exp_phase(exp_q[c]), exp_lamps(exp_q[c])});
            else n_pass++;
            night = (c >= 10) && (c < 25);
        end
        night = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_side();
        test_side_late();
        test_ped();
        test_both();
        test_clear_wins();
        test_back_to_back();
        test_rst_mid();
`ifdef NIGHT_FLASH_EN
        test_night();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
